// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access-size
// encodings taken from funct3, and byte/offset masks derived from a size.
package lsu_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} lsu_state_e;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;
   localparam int         F3_UNSIGNED = 2;

   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         SZ_B:    return 8'h01;
         SZ_H:    return 8'h03;
         SZ_W:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   // Offset bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] low_mask(input logic [1:0] sz);
      case (sz)
         SZ_B:    return 3'b000;
         SZ_H:    return 3'b001;
         SZ_W:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: byte enables, store data placement and
// load data extraction with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2:0]      off_i,
   input  logic [1:0]      size_i,
   input  logic            zext_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [7:0]      be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] ld_o
);

   logic [XLEN-1:0] rsh;

   assign be_o    = size_mask(size_i) << off_i;
   assign wdata_o = wdata_i << {off_i, 3'b000};
   assign rsh     = rdata_i >> {off_i, 3'b000};

   always_comb begin
      ld_o = rsh;
      case (size_i)
         SZ_B:    ld_o = {{(XLEN-8){~zext_i & rsh[7]}}, rsh[7:0]};
         SZ_H:    ld_o = {{(XLEN-16){~zext_i & rsh[15]}}, rsh[15:0]};
         SZ_W:    ld_o = {{(XLEN-32){~zext_i & rsh[31]}}, rsh[31:0]};
         default: ld_o = rsh;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV64I memory-access stage: one LOAD/STORE in flight, IDLE->REQ->WAIT->RESP.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_is_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [4:0]      req_rd,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic            resp_we,
   output logic [4:0]      resp_rd,
   output logic [XLEN-1:0] resp_data,
   output logic            resp_err,
   output logic            resp_misalign,
   output logic            mem_req,
   input  logic            mem_gnt,
   output logic [XLEN-1:0] mem_addr,
   output logic            mem_we,
   output logic [7:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_err
);

   localparam int CW = $clog2(TIMEOUT_CYC) + 1;

   lsu_state_e      state_q;
   logic            is_store_q, err_q, mis_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] addr_q, wdata_q, data_q;
   logic [4:0]      rd_q;
   logic [CW-1:0]   cnt_q;

   logic            illegal, misal;
   logic [2:0]      off;
   logic [7:0]      be;
   logic [XLEN-1:0] wsh, ld;

   assign illegal = req_is_store ? req_funct3[F3_UNSIGNED] : (req_funct3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
   assign misal = |(req_addr[2:0] & low_mask(req_funct3[1:0]));
`else
   assign misal = 1'b0;
`endif
   // Misaligned accesses only reach the bus when trapping is off; align them down.
   assign off = addr_q[2:0] & ~low_mask(f3_q[1:0]);

   lsu_align #(.XLEN(XLEN)) u_align (
      .off_i   (off),
      .size_i  (f3_q[1:0]),
      .zext_i  (f3_q[F3_UNSIGNED]),
      .wdata_i (wdata_q),
      .rdata_i (mem_rdata),
      .be_o    (be),
      .wdata_o (wsh),
      .ld_o    (ld)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         is_store_q <= 1'b0;
         f3_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         err_q      <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (req_valid) begin
               is_store_q <= req_is_store;
               f3_q       <= req_funct3;
               addr_q     <= req_addr;
               wdata_q    <= req_wdata;
               rd_q       <= req_rd;
               data_q     <= '0;
               err_q      <= illegal | misal;
               mis_q      <= misal;
               state_q    <= (illegal | misal) ? ST_RESP : ST_REQ;
            end
            ST_REQ: if (mem_gnt) begin
               cnt_q   <= '0;
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               cnt_q <= cnt_q + CW'(1);
               // A response arriving on the timeout cycle still counts.
               if (mem_rvalid) begin
                  err_q   <= mem_err;
                  data_q  <= (is_store_q | mem_err) ? '0 : ld;
                  state_q <= ST_RESP;
               end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: if (resp_ready) state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready     = (state_q == ST_IDLE);
   assign mem_req       = (state_q == ST_REQ);
   assign mem_addr      = {addr_q[XLEN-1:3], 3'b000};
   assign mem_we        = mem_req & is_store_q;
   assign mem_be        = mem_req ? be : 8'h00;
   assign mem_wdata     = mem_req ? wsh : '0;
   assign resp_valid    = (state_q == ST_RESP);
   assign resp_rd       = rd_q;
   assign resp_data     = data_q;
   assign resp_err      = resp_valid & err_q;
   assign resp_misalign = resp_valid & mis_q;
   assign resp_we       = resp_valid & ~is_store_q & ~err_q & ~mis_q & (rd_q != 5'd0);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed spec scenarios plus
// randomized accesses checked against a byte-level reference model.
module tb_load_store_unit;

   localparam int TO = 255;

   logic        clk = 1'b0, reset = 1'b1;
   logic        req_valid = 0, req_ready, req_is_store = 0;
   logic [2:0]  req_funct3 = 0;
   logic [63:0] req_addr = 0, req_wdata = 0;
   logic [4:0]  req_rd = 0;
   logic        resp_valid, resp_ready = 0, resp_we, resp_err, resp_misalign;
   logic [4:0]  resp_rd;
   logic [63:0] resp_data;
   logic        mem_req, mem_gnt = 0, mem_we, mem_rvalid = 0, mem_err = 0;
   logic [63:0] mem_addr, mem_wdata, mem_rdata = 0;
   logic [7:0]  mem_be;

   int errors = 0, checks = 0;

   load_store_unit #(.XLEN(64), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we), .resp_rd(resp_rd),
      .resp_data(resp_data), .resp_err(resp_err), .resp_misalign(resp_misalign),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          done, saw_req, stable;
      logic [63:0] addr, wdata, data;
      logic [7:0]  be;
      logic        we, rwe, err, mis;
      logic [4:0]  rd;
      int          lat, nreq;
   } obs_t;

   typedef struct {
      bit          bus;
      logic [63:0] addr, wdata, data;
      logic [7:0]  be;
      logic        we, rwe, err, mis;
   } exp_t;

   // Reference: byte-oriented view of an RV64 access.
   function automatic exp_t model(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                                  input logic [63:0] wdata, input logic [63:0] rdata,
                                  input bit merr, input logic [4:0] rd);
      exp_t e;
      int nb = 1 << f3[1:0];
      int off = int'(addr[2:0]);
      bit ill = st ? f3[2] : (f3 == 3'd7);
      bit mis = (off % nb) != 0;
      logic [63:0] v;
`ifndef LSU_MISALIGN_TRAP_EN
      off = off - (off % nb);
      mis = 0;
`endif
      e.bus = !(ill || mis);
      e.addr = addr & ~64'h7;
      e.we = st;
      e.be = 0;
      for (int i = 0; i < nb; i++) e.be[off + i] = 1'b1;
      e.wdata = wdata << (8 * off);
      v = rdata >> (8 * off);
      if (nb < 8) begin
         v = v & ((64'd1 << (8 * nb)) - 1);
         if (!f3[2] && v[8 * nb - 1]) v = v | ~((64'd1 << (8 * nb)) - 1);
      end
      e.mis = mis;
      e.err = ill || mis || (e.bus && merr);
      e.data = (st || e.err) ? 64'd0 : v;
      e.rwe = !st && !e.err && (rd != 0);
      return e;
   endfunction

   // Drives one access and services the bus; records what it saw. No checking.
   task automatic drive(input bit st, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [4:0] rd, input int gnt_dly,
                        input int rv_dly, input logic [63:0] rdata, input bit merr,
                        input bit no_rv, output obs_t o);
      int cyc = 1, nwait = 0, n = 0;
      bit phase = 0;
      o = '{default: 0};
      o.stable = 1;
      @(negedge clk);
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      req_valid = 1; req_is_store = st; req_funct3 = f3; req_addr = addr;
      req_wdata = wdata; req_rd = rd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      while (cyc < 2000) begin
         mem_gnt = 0; mem_rvalid = 0; mem_err = 0;
         if (resp_valid) begin
            o.done = 1; o.lat = cyc; o.data = resp_data; o.rwe = resp_we; o.err = resp_err;
            o.mis = resp_misalign; o.rd = resp_rd;
            resp_ready = 1;
            @(posedge clk);
            @(negedge clk);
            resp_ready = 0;
            break;
         end
         if (mem_req) begin
            if (!o.saw_req) begin
               o.addr = mem_addr; o.wdata = mem_wdata; o.be = mem_be; o.we = mem_we;
            end else if (o.addr !== mem_addr || o.wdata !== mem_wdata || o.be !== mem_be ||
                         o.we !== mem_we) o.stable = 0;
            o.saw_req = 1;
            if (o.nreq >= gnt_dly) begin mem_gnt = 1; phase = 1; nwait = 0; end
            o.nreq++;
         end else if (phase) begin
            nwait++;
            if (nwait == rv_dly && !no_rv) begin
               mem_rvalid = 1; mem_rdata = rdata; mem_err = merr;
            end
         end
         @(posedge clk);
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      checks++; if ({resp_valid, resp_we, resp_err, resp_misalign, mem_req, mem_we} !== 6'b0 ||
                    resp_data !== 64'd0 || mem_addr !== 64'd0 || mem_be !== 8'd0 || mem_wdata !== 64'd0) begin
         errors++; $display("FAIL reset_outputs: nonzero output vld=%b req=%b data=%h be=%h", resp_valid, mem_req, resp_data, mem_be);
      end
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_directed;
      obs_t o;
      drive(0, 3'b000, 64'h8000_0003, 64'd0, 5'd7, 0, 1, 64'h0000_0000_8000_0000, 0, 0, o);
      checks++; if (o.be !== 8'h08) begin errors++; $display("FAIL lb_be: got %h want 08", o.be); end
      checks++; if (o.data !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_data: got %h want ffffffffffffff80", o.data); end
      checks++; if (o.rwe !== 1'b1 || o.rd !== 5'd7) begin errors++; $display("FAIL lb_we: got we=%b rd=%0d want 1/7", o.rwe, o.rd); end
      checks++; if (o.lat != 3) begin errors++; $display("FAIL lb_latency: got %0d want 3", o.lat); end
      checks++; if (o.addr !== 64'h8000_0000) begin errors++; $display("FAIL lb_addr: got %h want 80000000", o.addr); end
      drive(0, 3'b110, 64'h1000_0004, 64'd0, 5'd9, 0, 1, 64'h8765_4321_0000_0000, 0, 0, o);
      checks++; if (o.be !== 8'hF0) begin errors++; $display("FAIL lwu_be: got %h want f0", o.be); end
      checks++; if (o.data !== 64'h0000_0000_8765_4321) begin errors++; $display("FAIL lwu_data: got %h want 87654321", o.data); end
      drive(1, 3'b001, 64'h2000_0006, 64'hABCD, 5'd3, 0, 1, 64'd0, 0, 0, o);
      checks++; if (o.we !== 1'b1 || o.be !== 8'hC0) begin errors++; $display("FAIL sh_bus: got we=%b be=%h want 1/c0", o.we, o.be); end
      checks++; if (o.wdata !== 64'hABCD_0000_0000_0000) begin errors++; $display("FAIL sh_wdata: got %h want abcd000000000000", o.wdata); end
      checks++; if (o.rwe !== 1'b0 || o.data !== 64'd0) begin errors++; $display("FAIL sh_resp: got we=%b data=%h want 0/0", o.rwe, o.data); end
   endtask

   task automatic test_gnt_stall;
      obs_t o;
      drive(0, 3'b011, 64'h3000_0008, 64'd0, 5'd4, 20, 2, 64'h1122_3344_5566_7788, 0, 0, o);
      checks++; if (o.nreq != 21 || !o.stable) begin errors++; $display("FAIL gnt_stall_req: got nreq=%0d stable=%0d want 21/1", o.nreq, o.stable); end
      checks++; if (o.data !== 64'h1122_3344_5566_7788 || o.lat != 24) begin
         errors++; $display("FAIL gnt_stall_resp: got data=%h lat=%0d want 1122334455667788/24", o.data, o.lat);
      end
   endtask

   task automatic test_timeout;
      obs_t o;
      drive(0, 3'b010, 64'h4000_0000, 64'd0, 5'd5, 0, 1, 64'd0, 0, 1, o);
      checks++; if (o.err !== 1'b1 || o.rwe !== 1'b0 || o.data !== 64'd0) begin
         errors++; $display("FAIL timeout_err: got err=%b we=%b data=%h want 1/0/0", o.err, o.rwe, o.data);
      end
      checks++; if (o.lat != TO + 2) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", o.lat, TO + 2); end
      mem_rvalid = 1; mem_err = 1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      mem_rvalid = 0; mem_err = 0;
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         errors++; $display("FAIL late_rvalid: got ready=%b vld=%b want 1/0", req_ready, resp_valid);
      end
      drive(0, 3'b100, 64'h4000_0001, 64'd0, 5'd6, 0, 1, 64'h0000_0000_0000_9A00, 0, 0, o);
      checks++; if (o.data !== 64'h9A || o.err !== 1'b0 || o.rwe !== 1'b1) begin
         errors++; $display("FAIL after_timeout: got data=%h err=%b we=%b want 9a/0/1", o.data, o.err, o.rwe);
      end
   endtask

   task automatic test_misalign;
      obs_t o;
      drive(0, 3'b010, 64'h5000_0002, 64'd0, 5'd8, 0, 1, 64'hCAFE_F00D_1234_5678, 0, 0, o);
`ifdef LSU_MISALIGN_TRAP_EN
      checks++; if (o.mis !== 1'b1 || o.err !== 1'b1 || o.saw_req) begin
         errors++; $display("FAIL misalign_trap: got mis=%b err=%b req=%0d want 1/1/0", o.mis, o.err, o.saw_req);
      end
`else
      checks++; if (o.be !== 8'h0F || o.mis !== 1'b0 || o.data !== 64'h0000_0000_1234_5678) begin
         errors++; $display("FAIL misalign_align: got be=%h mis=%b data=%h want 0f/0/12345678", o.be, o.mis, o.data);
      end
`endif
   endtask

   task automatic test_illegal;
      obs_t o;
      drive(0, 3'b111, 64'h6000_0000, 64'd0, 5'd2, 0, 1, 64'd0, 0, 0, o);
      checks++; if (o.err !== 1'b1 || o.saw_req || o.rwe !== 1'b0 || o.lat != 1) begin
         errors++; $display("FAIL illegal_load: got err=%b req=%0d we=%b lat=%0d want 1/0/0/1", o.err, o.saw_req, o.rwe, o.lat);
      end
      drive(1, 3'b100, 64'h6000_0000, 64'h55, 5'd2, 0, 1, 64'd0, 0, 0, o);
      checks++; if (o.err !== 1'b1 || o.saw_req) begin errors++; $display("FAIL illegal_store: got err=%b req=%0d want 1/0", o.err, o.saw_req); end
      drive(0, 3'b011, 64'h6000_0010, 64'd0, 5'd2, 0, 2, 64'h77, 1, 0, o);
      checks++; if (o.err !== 1'b1 || o.data !== 64'd0 || o.rwe !== 1'b0) begin
         errors++; $display("FAIL bus_error: got err=%b data=%h we=%b want 1/0/0", o.err, o.data, o.rwe);
      end
   endtask

   task automatic test_reset_in_wait;
      @(negedge clk);
      req_valid = 1; req_is_store = 0; req_funct3 = 3'b011; req_addr = 64'h7000_0000; req_rd = 5'd1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0; mem_gnt = 1;
      @(posedge clk);
      @(negedge clk);
      mem_gnt = 0;
      checks++; if (req_ready !== 1'b0 || mem_req !== 1'b0) begin
         errors++; $display("FAIL wait_state: got ready=%b req=%b want 0/0", req_ready, mem_req);
      end
      #1 reset = 1;
      #1;
      checks++; if (req_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
         errors++; $display("FAIL reset_in_wait: got ready=%b req=%b vld=%b want 1/0/0", req_ready, mem_req, resp_valid);
      end
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_random;
      obs_t o;
      exp_t e;
      for (int k = 0; k < 60; k++) begin
         bit st = $urandom_range(0, 1) == 1;
         logic [2:0] f3 = 3'($urandom_range(0, 7));
         logic [63:0] addr = {$urandom(), $urandom()};
         logic [63:0] wd = {$urandom(), $urandom()};
         logic [63:0] rdat = {$urandom(), $urandom()};
         logic [4:0] rd = 5'($urandom_range(0, 31));
         bit merr = $urandom_range(0, 9) == 0;
         int gd = $urandom_range(0, 3), rv = $urandom_range(1, 3);
         e = model(st, f3, addr, wd, rdat, merr, rd);
         drive(st, f3, addr, wd, rd, gd, rv, rdat, merr, 0, o);
         checks++;
         if (!o.done || o.saw_req != e.bus ||
             (e.bus && (o.addr !== e.addr || o.be !== e.be || o.we !== e.we ||
                        (st && o.wdata !== e.wdata))) ||
             o.data !== e.data || o.err !== e.err || o.mis !== e.mis || o.rwe !== e.rwe ||
             o.rd !== rd || o.lat != (e.bus ? 2 + gd + rv : 1)) begin
            errors++;
            $display("FAIL random_%0d: st=%0d f3=%0d a=%h got be=%h wd=%h data=%h err=%b mis=%b we=%b lat=%0d want be=%h wd=%h data=%h err=%b mis=%b we=%b",
                     k, st, f3, addr, o.be, o.wdata, o.data, o.err, o.mis, o.rwe, o.lat,
                     e.be, e.wdata, e.data, e.err, e.mis, e.rwe);
         end
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_gnt_stall;
      test_timeout;
      test_misalign;
      test_illegal;
      test_reset_in_wait;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
